// File: rtl/alu_muldiv_pkg.sv
// Shared opcode codes and helpers for the iterative multiply/divide unit.
// The MD_* values sit beside the ALU opcodes used by the execute stage.
package alu_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Signed ops work on magnitudes and fix up the sign afterwards.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Radix-2 datapath of the mul/div unit: operand registers, step counter and
// a shared (2*WIDTH+1)-bit accumulator used for shift-add multiply and
// restoring shift-subtract divide. Works on unsigned magnitudes only.
// MULDIV_DIV_EN: when undefined, only the multiply step is built.
module alu_muldiv_core
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               div_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   step_next;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic [2*WIDTH:0]   div_shl;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH:0]   div_next;

    // Divide: shift {rem, quo} left, keep the trial subtraction only if it does not borrow.
    assign div_shl   = {acc_q[2*WIDTH-1:0], 1'b0};
    assign div_diff  = {1'b0, div_shl[2*WIDTH:WIDTH]} - {2'b00, b_q};
    assign div_next  = div_diff[WIDTH+1] ? div_shl
                                         : {div_diff[WIDTH:0], div_shl[WIDTH-1:1], 1'b1};
    assign step_next = div_q ? div_next : mul_next;
`else
    logic unused_div;
    assign unused_div = div_q;
    assign step_next  = mul_next;
`endif

    // Load operands on start, otherwise advance one radix-2 step per enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        if (start_i) begin
            cnt_d = CW'(WIDTH);
            acc_d = {{(WIDTH+1){1'b0}}, a_i};
            b_d   = b_i;
            div_d = div_i;
        end else if (step_i) begin
            cnt_d = cnt_q - CW'(1);
            acc_d = step_next;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign acc_o  = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Holds the FSM, valid/ready handshake, HI/LO and the sign fixup; the
// radix-2 datapath lives in alu_muldiv_core.
// MULDIV_DIV_EN: define to build DIV/DIVU; otherwise they report op_err.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             op_err,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic                  dbz_q, dbz_d, err_q, err_d;
    logic                  is_div_q, neg_q, xneg_q, yzero_q;
    logic [WIDTH-1:0]      x_q;
    logic                  op_mul, op_div, op_sgn, accept, start, core_last;
    logic [WIDTH-1:0]      x_abs, y_abs;
    logic [2*WIDTH-1:0]    core_acc;
    logic [WIDTH-1:0]      quo, rem;

    assign op_mul = (req_op == MD_MULT) || (req_op == MD_MULTU);
`ifdef MULDIV_DIV_EN
    assign op_div = (req_op == MD_DIV) || (req_op == MD_DIVU);
`else
    assign op_div = 1'b0;
`endif
    assign op_sgn = is_signed_op(req_op);
    assign x_abs  = (op_sgn && req_x[WIDTH-1]) ? -req_x : req_x;
    assign y_abs  = (op_sgn && req_y[WIDTH-1]) ? -req_y : req_y;
    assign accept = req_valid && (state_q == ST_IDLE) && !flush;
    assign quo    = core_acc[WIDTH-1:0];
    assign rem    = core_acc[2*WIDTH-1:WIDTH];

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .div_i   (op_div),
        .step_i  (state_q == ST_CALC),
        .a_i     (x_abs),
        .b_i     (y_abs),
        .last_o  (core_last),
        .acc_o   (core_acc)
    );

    // Next state, HI/LO writes and result flags; flush beats the FIXUP commit.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    err_d = 1'b0;
                    if (req_op == MD_MTHI) begin
                        hi_d = req_x;
                    end else if (req_op == MD_MTLO) begin
                        lo_d = req_x;
                    end else if (op_mul || op_div) begin
                        start   = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (core_last) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (is_div_q) begin
                        if (yzero_q) begin
                            hi_d  = x_q;
                            lo_d  = '1;
                            dbz_d = 1'b1;
                        end else begin
                            lo_d = neg_q  ? -quo : quo;
                            hi_d = xneg_q ? -rem : rem;
                        end
                    end else begin
                        {hi_d, lo_d} = neg_q ? -core_acc : core_acc;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, HI/LO and result flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
        end
    end

    // Sign and divide-by-zero bookkeeping captured at accept for the fixup cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            xneg_q   <= 1'b0;
            yzero_q  <= 1'b0;
            x_q      <= '0;
        end else if (start) begin
            is_div_q <= op_div;
            neg_q    <= op_sgn && (req_x[WIDTH-1] ^ req_y[WIDTH-1]);
            xneg_q   <= op_sgn && req_x[WIDTH-1];
            yzero_q  <= (req_y == '0);
            x_q      <= req_x;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign div_by_zero = dbz_q && res_valid;
    assign op_err      = err_q && res_valid;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam logic [31:0] RST_V = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] hi, lo;
    logic        div_by_zero, op_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] hi_m = RST_V;
    logic [31:0] lo_m = RST_V;

    alu_muldiv #(.WIDTH(32), .HILO_RST(RST_V)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_x       (req_x),
        .req_y       (req_y),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .op_err      (op_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result of one op, computed with plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic ed, output logic ee, output int lat, output bit mt);
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        eh = hi_m; el = lo_m; ed = 1'b0; ee = 1'b0; lat = 33; mt = 1'b0;
        case (op)
            MD_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {eh, el} = sp;
            end
            MD_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                {eh, el} = up;
            end
            MD_DIV, MD_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF; ed = 1'b1;
                end else if (op == MD_DIVU) begin
                    eh = x % y; el = x / y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    eh = 32'd0; el = 32'h8000_0000;
                end else begin
                    sq = $signed(x) / $signed(y);
                    sr = $signed(x) % $signed(y);
                    eh = sr; el = sq;
                end
`else
                ee = 1'b1; lat = 0;
`endif
            end
            MD_MTHI: begin eh = x; mt = 1'b1; end
            MD_MTLO: begin el = x; mt = 1'b1; end
            default: begin ee = 1'b1; lat = 0; end
        endcase
    endtask

    // Issue one request, wait for its result, hold res_ready low for `hold` cycles, then consume.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [31:0] eh, el;
        logic        ed, ee;
        int          lat, exp_lat;
        bit          mt;
        model(op, x, y, eh, el, ed, ee, exp_lat, mt);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mt) begin
            chk("mt_hi", hi, eh);
            chk("mt_lo", lo, el);
            chk("mt_no_res", res_valid, 1'b0);
        end else begin
            lat = 0;
            while (!res_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("[TB] op=%0d x=%h y=%h -> hi=%h lo=%h dbz=%b err=%b lat=%0d",
                     op, x, y, hi, lo, div_by_zero, op_err, lat);
            chk("latency", lat, exp_lat);
            chk("hi", hi, eh);
            chk("lo", lo, el);
            chk("div_by_zero", div_by_zero, ed);
            chk("op_err", op_err, ee);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_ready", req_ready, 1'b0);
                chk("hold_hi", hi, eh);
                chk("hold_lo", lo, el);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            chk("back_idle", req_ready, 1'b1);
            chk("res_dropped", res_valid, 1'b0);
        end
        hi_m = eh; lo_m = el;
    endtask

    // MULT flushed in cycle `cyc` after its accept edge (cycle 0).
    task automatic flush_test(input int cyc, input bit in_done);
        logic [31:0] eh, el;
        logic        ed, ee;
        int          lat;
        bit          mt;
        model(MD_MULT, 32'h1234_5678, 32'hFFFF_FF00, eh, el, ed, ee, lat, mt);
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_MULT; req_x = 32'h1234_5678; req_y = 32'hFFFF_FF00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i < cyc; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("[TB] flush in cycle %0d -> busy=%b res_valid=%b hi=%h lo=%h", cyc, busy, res_valid, hi, lo);
        if (!in_done) begin
            chk("flush_busy", busy, 1'b0);
            chk("flush_res", res_valid, 1'b0);
            chk("flush_hi", hi, hi_m);
            chk("flush_lo", lo, lo_m);
        end else begin
            chk("flush_done_valid", res_valid, 1'b1);
            chk("flush_done_hi", hi, eh);
            chk("flush_done_lo", lo, el);
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            chk("flush_done_idle", req_ready, 1'b1);
            hi_m = eh; lo_m = el;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [2:0] rop;
        int r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, RST_V);
        chk("rst_lo", lo, RST_V);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dbz", div_by_zero, 1'b0);
        chk("rst_err", op_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7, 0);
        run_op(MD_DIVU,  32'd100, 32'd7, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(MD_DIV,   32'd5, 32'd0, 0);
        run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        run_op(3'd6,     32'h1111_1111, 32'h2222_2222, 1);
        run_op(MD_MTLO,  32'hDEAD_BEEF, 32'd0, 0);
        run_op(MD_MTHI,  32'd1, 32'd0, 0);

        // Flush cases: mid-CALC, in FIXUP (no commit), in DONE (ignored).
        flush_test(10, 1'b0);
        flush_test(33, 1'b0);
        flush_test(34, 1'b1);

        // Request presented together with flush while idle is dropped.
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = MD_MTHI; req_x = ~hi_m;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        $display("[TB] idle flush -> busy=%b hi=%h", busy, hi);
        chk("idle_flush_hi", hi, hi_m);
        chk("idle_flush_busy", busy, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 15);
            rop = (r < 14) ? 3'(r % 6) : 3'(6 + (r % 2));
            run_op(rop, pick(), pick(), $urandom_range(0, 2));
        end

        // Reset in the middle of a divide.
        run_op(MD_MTHI, 32'hCAFE_0001, 32'd0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_DIV; req_x = 32'd1000; req_y = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("[TB] reset mid-op -> hi=%h lo=%h ready=%b", hi, lo, req_ready);
        chk("midrst_hi", hi, RST_V);
        chk("midrst_lo", lo, RST_V);
        chk("midrst_ready", req_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        hi_m = RST_V; lo_m = RST_V;
        run_op(MD_MULT, 32'h0000_1234, 32'hFFFF_0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
